// File: rtl/disp_share_arb.sv
// rtl/disp_share_arb.sv - round-robin arbiter sharing the 4-digit seven-segment display
module disp_share_arb #(
    parameter int NREQ       = 3,
    parameter int TICK_DIV   = 50000,
    parameter int HOLD_TICKS = 500
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   data,
    input  logic [4*NREQ-1:0]    dp,
    output logic [NREQ-1:0]      gnt,
    output logic [2:0]           owner,
    output logic                 busy,
    output logic [3:0]           hex3,
    output logic [3:0]           hex2,
    output logic [3:0]           hex1,
    output logic [3:0]           hex0,
    output logic [3:0]           dp_out
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = $clog2(HOLD_TICKS + 1);

    typedef enum logic [1:0] {IDLE, HOLD, OPEN} state_t;

    state_t          state;
    state_t          nxt_state;
    logic [PW-1:0]   psc;
    logic [HW-1:0]   hcnt;
    logic            tick;
    logic            hold_elapsed;
    logic            own_req;
    logic            others;
    logic            pick_found;
    logic            restart;
    logic [2:0]      pick_idx;
    logic [2:0]      nxt_owner;
    logic [15:0]     sel_data;
    logic [3:0]      sel_dp;

    assign tick    = (psc == PW'(TICK_DIV - 1));
    assign own_req = |(req & gnt);
    assign others  = |(req & ~gnt);

    // Elapsed is taken on the edge that completes the last tick, so ownership lasts exactly HOLD_TICKS*TICK_DIV cycles.
    assign hold_elapsed = (state == OPEN) ||
                          (state == HOLD && tick && hcnt == HW'(HOLD_TICKS - 1));

    // Nearest requester after the current owner wins; k runs downward so the smallest distance is written last.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = owner;
        for (int k = NREQ; k >= 1; k--) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && ((int'(owner) + k) % NREQ) == i) begin
                    pick_found = 1'b1;
                    pick_idx   = 3'(i);
                end
            end
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_owner = owner;
        restart   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    nxt_state = HOLD;
                    nxt_owner = pick_idx;
                    restart   = 1'b1;
                end
            end
            default: begin
                if ((hold_elapsed && others) || (!hold_elapsed && !own_req)) begin
                    if (pick_found) begin
                        nxt_state = HOLD;
                        nxt_owner = pick_idx;
                        restart   = 1'b1;
                    end else begin
                        nxt_state = IDLE;
                    end
                end else if (!own_req) begin
                    nxt_state = IDLE;
                end else if (hold_elapsed) begin
                    nxt_state = OPEN;
                end
            end
        endcase
    end

    always_comb begin
        sel_data = '0;
        sel_dp   = '1;
        for (int i = 0; i < NREQ; i++) begin
            if (nxt_owner == 3'(i)) begin
                sel_data = data[16*i +: 16];
                sel_dp   = dp[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            owner  <= 3'(NREQ - 1);
            gnt    <= '0;
            busy   <= 1'b0;
            hex3   <= '0;
            hex2   <= '0;
            hex1   <= '0;
            hex0   <= '0;
            dp_out <= 4'b1111;
            psc    <= '0;
            hcnt   <= '0;
        end else begin
            state <= nxt_state;
            owner <= nxt_owner;
            // Display is only reloaded while granted, so IDLE keeps the last owner's digits.
            if (nxt_state == IDLE) begin
                gnt  <= '0;
                busy <= 1'b0;
            end else begin
                gnt                    <= NREQ'(1) << nxt_owner;
                busy                   <= 1'b1;
                {hex3, hex2, hex1, hex0} <= sel_data;
                dp_out                 <= sel_dp;
            end
            if (restart) begin
                psc  <= '0;
                hcnt <= '0;
            end else if (state == HOLD) begin
                psc <= tick ? '0 : psc + 1'b1;
                if (tick && hcnt != HW'(HOLD_TICKS))
                    hcnt <= hcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_disp_share_arb.sv
// tb/tb_disp_share_arb.sv - self-checking bench for disp_share_arb
module tb_disp_share_arb;
    localparam int N    = 3;
    localparam int TD   = 4;
    localparam int HT   = 3;
    localparam int HOLD = TD * HT;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [16*N-1:0] data = '0;
    logic [4*N-1:0] dp = '1;
    logic [N-1:0]   gnt;
    logic [2:0]     owner;
    logic           busy;
    logic [3:0]     hex3, hex2, hex1, hex0, dp_out;
    logic [15:0]    hexw;

    assign hexw = {hex3, hex2, hex1, hex0};

    disp_share_arb #(.NREQ(N), .TICK_DIV(TD), .HOLD_TICKS(HT)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .data(data), .dp(dp),
        .gnt(gnt), .owner(owner), .busy(busy),
        .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0), .dp_out(dp_out)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = '0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Reference model: ownership age in cycles instead of prescaler/tick counters.
    bit          m_act;
    int          m_own;
    int          m_age;
    logic [15:0] m_hex;
    logic [3:0]  m_dp;

    function automatic int rr_pick(input int own, input int r);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (own + k) % N;
            if (((r >> idx) & 1) == 1) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_act = 1'b0;
        m_own = N - 1;
        m_age = 0;
        m_hex = '0;
        m_dp  = 4'hF;
    endtask

    task automatic model_step();
        int r, p;
        bit elapsed, own, oth;
        r = int'(req);
        p = rr_pick(m_own, r);
        if (!m_act) begin
            if (p >= 0) begin
                m_act = 1'b1; m_own = p; m_age = 0;
            end
        end else begin
            elapsed = (m_age + 1 >= HOLD);
            own     = ((r >> m_own) & 1) == 1;
            oth     = (r & ~(1 << m_own)) != 0;
            if ((elapsed && oth) || (!elapsed && !own)) begin
                if (p >= 0) begin
                    m_own = p; m_age = 0;
                end else begin
                    m_act = 1'b0;
                end
            end else if (!own) begin
                m_act = 1'b0;
            end else begin
                m_age++;
            end
        end
        if (m_act) begin
            m_hex = data[16*m_own +: 16];
            m_dp  = dp[4*m_own +: 4];
        end
    endtask

    task automatic model_check();
        check("rnd_gnt",   gnt,   m_act ? (1 << m_own) : 0);
        check("rnd_owner", owner, m_own);
        check("rnd_busy",  busy,  m_act);
        check("rnd_hex",   hexw,  m_hex);
        check("rnd_dp",    dp_out, m_dp);
    endtask

    typedef struct {
        logic [2:0]  req;
        logic [47:0] data;
        logic [11:0] dp;
        logic [2:0]  e_gnt;
        logic [2:0]  e_own;
        logic        e_busy;
        logic [15:0] e_hex;
        logic [3:0]  e_dp;
    } vec_t;

    vec_t vec[9];

    initial begin
        int cnt, bad;
        int exp_seq[4];
        logic [47:0] da, db;
        logic [11:0] dpv;

        da  = {16'hCAFE, 16'hBEEF, 16'h1234};
        db  = {16'hCAFE, 16'hBEEF, 16'h5678};
        dpv = {4'b1011, 4'b0111, 4'b1110};
        vec[0] = '{3'b000, da, dpv, 3'b000, 3'd2, 1'b0, 16'h0000, 4'hF};
        vec[1] = '{3'b001, da, dpv, 3'b001, 3'd0, 1'b1, 16'h1234, 4'hE};
        vec[2] = '{3'b001, db, dpv, 3'b001, 3'd0, 1'b1, 16'h5678, 4'hE};
        vec[3] = '{3'b000, db, dpv, 3'b000, 3'd0, 1'b0, 16'h5678, 4'hE};
        vec[4] = '{3'b010, db, dpv, 3'b010, 3'd1, 1'b1, 16'hBEEF, 4'h7};
        vec[5] = '{3'b110, db, dpv, 3'b010, 3'd1, 1'b1, 16'hBEEF, 4'h7};
        vec[6] = '{3'b100, db, dpv, 3'b100, 3'd2, 1'b1, 16'hCAFE, 4'hB};
        vec[7] = '{3'b000, db, dpv, 3'b000, 3'd2, 1'b0, 16'hCAFE, 4'hB};
        vec[8] = '{3'b011, da, dpv, 3'b001, 3'd0, 1'b1, 16'h1234, 4'hE};

        do_reset();
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_owner", owner, N - 1);
        check("rst_hex", hexw, 0);
        check("rst_dp", dp_out, 4'hF);

        for (int v = 0; v < 9; v++) begin
            req = vec[v].req; data = vec[v].data; dp = vec[v].dp;
            step();
            check($sformatf("vec%0d_gnt", v), gnt, vec[v].e_gnt);
            check($sformatf("vec%0d_owner", v), owner, vec[v].e_own);
            check($sformatf("vec%0d_busy", v), busy, vec[v].e_busy);
            check($sformatf("vec%0d_hex", v), hexw, vec[v].e_hex);
            check($sformatf("vec%0d_dp", v), dp_out, vec[v].e_dp);
        end

        // Full contention rotates 0,1,2,0 with exactly HOLD cycles each
        do_reset();
        data = {16'hCCCC, 16'hBBBB, 16'hAAAA};
        req  = 3'b111;
        exp_seq = '{0, 1, 2, 0};
        bad = 0;
        step();
        for (int s = 0; s < 3; s++) begin
            check($sformatf("rot%0d_gnt", s), gnt, 1 << exp_seq[s]);
            check($sformatf("rot%0d_hex", s), hexw, data[16*exp_seq[s] +: 16]);
            cnt = 0;
            while (gnt == N'(1 << exp_seq[s]) && cnt < 40) begin
                cnt++;
                step();
                if ($countones(gnt) != 1) bad++;
            end
            check($sformatf("rot%0d_len", s), cnt, HOLD);
        end
        check("rot_wrap_gnt", gnt, 3'b001);
        check("rot_onehot", bad, 0);

        // Lone owner keeps the grant and tracks live data
        do_reset();
        data = {16'h0, 16'h0, 16'h1111};
        req  = 3'b001;
        step();
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            if (c == 20) data[15:0] = 16'hABCD;
            step();
            if (gnt != 3'b001) bad++;
            if (c == 19) check("alone_hex_old", hexw, 16'h1111);
            if (c == 20) check("alone_hex_new", hexw, 16'hABCD);
        end
        check("alone_no_drop", bad, 0);

        // Owner 1 self-releases mid-hold with requester 2 pending
        do_reset();
        data = {16'hCAFE, 16'hBEEF, 16'h1234};
        req  = 3'b110;
        step();
        check("drop_gnt1", gnt, 3'b010);
        for (int c = 0; c < 4; c++) step();
        req = 3'b100;
        step();
        check("drop_gnt2", gnt, 3'b100);
        check("drop_owner2", owner, 2);
        check("drop_hex2", hexw, 16'hCAFE);
        req = 3'b110;
        cnt = 1;
        while (gnt == 3'b100 && cnt < 40) begin
            step();
            if (gnt == 3'b100) cnt++;
        end
        check("drop_restart_len", cnt, HOLD);
        check("drop_after_gnt", gnt, 3'b010);

        // Owner 1 self-releases with nobody else waiting
        do_reset();
        req = 3'b010;
        step();
        for (int c = 0; c < 4; c++) step();
        req = 3'b000;
        step();
        check("rel_gnt", gnt, 0);
        check("rel_busy", busy, 0);
        check("rel_hex", hexw, 16'hBEEF);

        // Owner 2 in OPEN; 0 and 1 rise together, 0 wins via wrap
        do_reset();
        req = 3'b100;
        step();
        check("open_gnt2", gnt, 3'b100);
        for (int c = 0; c < 15; c++) step();
        req = 3'b111;
        step();
        check("open_wrap_gnt", gnt, 3'b001);
        check("open_wrap_owner", owner, 0);

        // Asynchronous reset mid-hold
        do_reset();
        data = {16'hCAFE, 16'hBEEF, 16'h1234};
        dp   = {4'b1011, 4'b0111, 4'b1110};
        req  = 3'b001;
        step();
        for (int c = 0; c < 3; c++) step();
        #2 reset_n = 1'b0;
        #1;
        check("arst_gnt", gnt, 0);
        check("arst_busy", busy, 0);
        check("arst_hex", hexw, 0);
        check("arst_dp", dp_out, 4'hF);
        check("arst_owner", owner, N - 1);
        req = 3'b110;
        #1 reset_n = 1'b1;
        step();
        check("arst_first_gnt", gnt, 3'b010);
        check("arst_first_owner", owner, 1);

        // Randomised traffic against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) req = req ^ N'(1 << $urandom_range(0, N - 1));
            if ($urandom_range(0, 3) == 0) data = 48'({$urandom(), $urandom()});
            if ($urandom_range(0, 3) == 0) dp = 12'($urandom());
            @(posedge clk);
            model_step();
            #1;
            model_check();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/disp_share_arb.md
Name: disp_share_arb

Overview:
- Round-robin arbiter that shares the single 4-digit seven-segment display (hex-digit/decimal-point inputs of the display multiplexer) between NREQ requesters.
- Each requester presents a 16-bit hex word plus 4 decimal-point bits.
- The winner owns the display for a guaranteed minimum hold time, then ownership rotates to other pending requesters.
- Sits between application blocks (counters, status, error codes) and the display multiplexer.

Parameters:
- NREQ, 3, number of requesters (2..8).
- TICK_DIV, 50000, clk cycles per hold tick (1 ms at 50 MHz).
- HOLD_TICKS, 500, minimum ownership time in ticks.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  NREQ  request per requester, level-sensitive.
- data  in  16*NREQ  requester i digits at [16i+15:16i]; nibble 3 = leftmost digit.
- dp  in  4*NREQ  requester i decimal points at [4i+3:4i], active-low (1 = off).
- gnt  out  NREQ  one-hot grant, registered.
- owner  out  3  index of current or last owner.
- busy  out  1  a grant is active.
- hex3, hex2, hex1, hex0  out  4 each  digits to display mux.
- dp_out  out  4  decimal points to display mux.

Behaviour:
- Reset (async, while reset_n=0): gnt=0, busy=0, owner=NREQ-1 (so requester 0 wins first), hex3..hex0=0, dp_out=4'b1111, prescaler=0, hold counter=0, state IDLE.
- All outputs are registered. No combinational path from inputs to outputs.
- FSM states:
  - IDLE: no owner.
  - HOLD: owner active, hold time not yet elapsed.
  - OPEN: owner active, hold elapsed, re-arbitration allowed.
- Arbitration: round-robin. Search order is owner+1, owner+2, ... mod NREQ. First requester found with req=1 wins.
- IDLE, any req=1 at edge t:
  - At t+1: gnt = one-hot winner, owner = winner index, busy=1, state HOLD.
  - Prescaler and hold counter cleared.
- While granted (HOLD or OPEN):
  - Each edge loads hex3..hex0 and dp_out from the owner's data/dp slice.
  - Display therefore tracks the owner's live value with 1-cycle latency.
- Prescaler: counts 0..TICK_DIV-1 and emits a 1-cycle tick on wrap. It is cleared on every new grant, so hold time is exactly HOLD_TICKS*TICK_DIV cycles after gnt rises.
- Hold counter:
  - Increments on tick in HOLD.
  - On reaching HOLD_TICKS, go to OPEN on the next edge.
  - Saturates; no wrap.
- OPEN, evaluated each edge:
  - If any other requester has req=1, rotate: winner per round-robin from owner+1, gnt/owner update next cycle, return to HOLD, counters cleared.
  - Else if the owner's req=1, stay in OPEN; the owner keeps the display with no re-grant glitch.
  - Else release: gnt=0, busy=0, state IDLE.
- Owner drops req during HOLD: release immediately (no minimum-hold enforcement on self-release).
  - Next edge: if other requests are pending, grant the next one (HOLD, counters cleared); else go to IDLE.
  - No idle cycle is inserted between owners.
- IDLE display: hex3..hex0 and dp_out hold the last owner's final value; the display is never blanked.
- Grant handover: gnt changes in a single edge, never two bits high at once. The new owner's data appears on hex outputs in the same cycle its gnt rises. That data is the value sampled on the switching edge.
- Simultaneous events: if a new request arrives on the same edge the owner self-releases, the round-robin pick among currently high req bits applies.
- Out-of-range owner index cannot occur. owner width is fixed at 3 and unused codes are unreachable.
- Asynchronous reset mid-grant: all outputs return to reset values immediately. Arbitration restarts from requester 0.

Test Plan (TICK_DIV=4, HOLD_TICKS=3, so hold = 12 cycles, NREQ=3):
- Reset release, then req=3'b001 with data0=16'h1234, dp0=4'b1110 -> one cycle later gnt=001, owner=0, busy=1, {hex3..hex0}=1,2,3,4, dp_out=1110. Before that: hex=0, dp_out=1111.
- req=3'b111 held from IDLE -> grants 0, then 1, then 2, then 0. Each gnt lasts exactly 12 cycles. gnt stays one-hot throughout. Each owner's data appears the same cycle its gnt rises.
- Owner 0 alone holds req for 40 cycles -> gnt=001 continuously with no drop. Changing data0 to 16'hABCD at cycle 20 shows A,B,C,D at cycle 21.
- Owner 1 granted, req1 drops at cycle 5 of hold while req2=1 -> next edge gnt=100, owner=2, hold restarts (12 cycles). With req2=0 instead: gnt=000, busy=0, hex keeps data1.
- Owner 2 in OPEN, req0 and req1 both rise on the same edge -> requester 0 wins (wrap after 2), gnt=001 next cycle.
- reset_n pulsed low mid-HOLD (asynchronously, between edges) -> gnt=0, busy=0, hex=0, dp_out=1111 immediately. After release with req=3'b110, requester 1 wins first.
